count_decode: RTL and testbench

Receive-side companion to the up/down `count` block. It samples the 8-bit count stream that `count` drives and recovers the per-cycle command that produced each step: hold, up (en=1, dir=1) or down (en=1, dir=0). It also tracks run lengths and direction reversals, and flags and counts illegal steps, so the bench or downstream logic can check the counter without probing its inputs.

---
 rtl/count_decode.sv | 146 ++++++++++++++
 tb/tb_count_decode.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/count_decode.sv
// count_decode
//
// Receive-side decoder for an 8-bit up/down count stream. Each accepted sample
// is compared with the previous one; a step of 0, +1 or -1 (modulo 2^WIDTH)
// recovers the hold / up / down command that produced it. Any other step is
// flagged as illegal, counted, and the decoder resynchronises on the new
// value. Run lengths and direct UP<->DOWN reversals are also reported.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset (overrides valid)
//   valid      in   q_in carries a new sample this cycle
//   q_in       in   observed count value [WIDTH]
//   dec_valid  out  1-cycle pulse: en_out/dir_out/state hold a new decode
//   en_out     out  recovered enable
//   dir_out    out  recovered direction (1 = up)
//   state      out  0 HOLD, 1 UP, 2 DOWN, 3 UNSYNC
//   dir_change out  1-cycle pulse: direct UP<->DOWN reversal
//   err        out  1-cycle pulse: illegal step
//   run_len    out  consecutive decodes in current state, saturating [RUN_W]
//   err_cnt    out  illegal steps since reset, saturating [ERR_W]
//   prev_q     out  last accepted sample [WIDTH]
//
// All outputs are registered; results appear one cycle after the sample.

module count_decode #(
  parameter int WIDTH = 8,
  parameter int RUN_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] q_in,
  output logic             dec_valid,
  output logic             en_out,
  output logic             dir_out,
  output logic [1:0]       state,
  output logic             dir_change,
  output logic             err,
  output logic [RUN_W-1:0] run_len,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] prev_q
);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_UP     = 2'd1,
    S_DOWN   = 2'd2,
    S_UNSYNC = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_d;
  logic               en_d, dir_d;
  logic               dec_valid_d, dir_change_d, err_d;
  logic [RUN_W-1:0]   run_d;
  logic [ERR_W-1:0]   err_cnt_d;

  // Step between this sample and the last one, modulo 2^WIDTH, so that
  // max->0 reads as +1 and 0->max reads as -1.
  logic [WIDTH-1:0]   diff;
  state_t             step;
  logic               legal;

  assign diff  = q_in - prev_q;
  assign state = state_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    prev_d       = prev_q;
    en_d         = en_out;
    dir_d        = dir_out;
    run_d        = run_len;
    err_cnt_d    = err_cnt;
    dec_valid_d  = 1'b0;
    dir_change_d = 1'b0;
    err_d        = 1'b0;
    step         = S_HOLD;
    legal        = 1'b1;

    if (diff == '0) begin
      step = S_HOLD;
    end else if (diff == WIDTH'(1)) begin
      step = S_UP;
    end else if (diff == '1) begin
      step = S_DOWN;
    end else begin
      legal = 1'b0;
    end

    if (valid) begin
      prev_d = q_in;
      if (state_q == S_UNSYNC) begin
        // First sample only establishes a reference; no step exists yet.
        state_d = S_HOLD;
        run_d   = '0;
      end else if (legal) begin
        dec_valid_d  = 1'b1;
        state_d      = step;
        en_d         = (step != S_HOLD);
        dir_d        = (step == S_UP);
        run_d        = (step != state_q) ? RUN_W'(1) :
                       (run_len == '1)   ? run_len   : run_len + 1'b1;
        // Only a direct reversal counts; going through HOLD does not.
        dir_change_d = (state_q == S_UP   && step == S_DOWN) ||
                       (state_q == S_DOWN && step == S_UP);
      end else begin
        // Resync on the new value; en/dir keep the last good decode.
        err_d     = 1'b1;
        err_cnt_d = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
        state_d   = S_HOLD;
        run_d     = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_UNSYNC;
      prev_q     <= '0;
      en_out     <= 1'b0;
      dir_out    <= 1'b0;
      run_len    <= '0;
      err_cnt    <= '0;
      dec_valid  <= 1'b0;
      dir_change <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      en_out     <= en_d;
      dir_out    <= dir_d;
      run_len    <= run_d;
      err_cnt    <= err_cnt_d;
      dec_valid  <= dec_valid_d;
      dir_change <= dir_change_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_count_decode.sv
// Self-checking bench for count_decode: a table of directed vectors with
// hand-computed expectations, hand-written sequences for error-counter
// saturation, and an end-to-end run against a small up/down counter model.

module tb_count_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] q_drv;
  logic [7:0] q_in;
  logic       dec_valid, en_out, dir_out, dir_change, err;
  logic [1:0] state;
  logic [7:0] run_len, err_cnt, prev_q;

  // Reference up/down counter standing in for the count block.
  logic       use_cnt = 1'b0;
  logic       cnt_rst = 1'b0;
  logic       cnt_en  = 1'b0;
  logic       cnt_dir = 1'b0;
  logic [7:0] cnt_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cnt_rst)     cnt_q <= 8'd0;
    else if (cnt_en) cnt_q <= cnt_dir ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end

  assign q_in = use_cnt ? cnt_q : q_drv;

  count_decode dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .q_in       (q_in),
    .dec_valid  (dec_valid),
    .en_out     (en_out),
    .dir_out    (dir_out),
    .state      (state),
    .dir_change (dir_change),
    .err        (err),
    .run_len    (run_len),
    .err_cnt    (err_cnt),
    .prev_q     (prev_q)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] q;
    logic       dv;
    logic       en;
    logic       dir;
    logic [1:0] st;
    logic       dc;
    logic       er;
    logic [7:0] rl;
    logic [7:0] ec;
    logic [7:0] pq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] q,
                     input logic dv, input logic en, input logic dir,
                     input logic [1:0] st, input logic dc, input logic er,
                     input logic [7:0] rl, input logic [7:0] ec, input logic [7:0] pq);
    vec_t t;
    t.rst = r; t.valid = v; t.q = q; t.dv = dv; t.en = en; t.dir = dir;
    t.st = st; t.dc = dc; t.er = er; t.rl = rl; t.ec = ec; t.pq = pq;
    vecs.push_back(t);
  endtask

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  logic exp_en, exp_dir, cur_en, cur_dir;

  initial begin
    rst = 1'b1; valid = 1'b0; q_drv = 8'd0;

    //   rst v  q      dv en dir st dc er rl  ec  pq
    add(1, 0, 8'h00, 0, 0, 0, 3, 0, 0, 0,  0,  8'h00);  // reset state
    // sync and hold
    add(0, 1, 8'h05, 0, 0, 0, 0, 0, 0, 0,  0,  8'h05);
    add(0, 1, 8'h05, 1, 0, 0, 0, 0, 0, 1,  0,  8'h05);
    add(0, 1, 8'h05, 1, 0, 0, 0, 0, 0, 2,  0,  8'h05);
    add(0, 1, 8'h05, 1, 0, 0, 0, 0, 0, 3,  0,  8'h05);
    // up run across the wrap
    add(1, 0, 8'h00, 0, 0, 0, 3, 0, 0, 0,  0,  8'h00);
    add(0, 1, 8'hFD, 0, 0, 0, 0, 0, 0, 0,  0,  8'hFD);
    add(0, 1, 8'hFE, 1, 1, 1, 1, 0, 0, 1,  0,  8'hFE);
    add(0, 1, 8'hFF, 1, 1, 1, 1, 0, 0, 2,  0,  8'hFF);
    add(0, 1, 8'h00, 1, 1, 1, 1, 0, 0, 3,  0,  8'h00);
    add(0, 1, 8'h01, 1, 1, 1, 1, 0, 0, 4,  0,  8'h01);
    // down run across the wrap, then direct reversal
    add(1, 0, 8'h00, 0, 0, 0, 3, 0, 0, 0,  0,  8'h00);
    add(0, 1, 8'h01, 0, 0, 0, 0, 0, 0, 0,  0,  8'h01);
    add(0, 1, 8'h00, 1, 1, 0, 2, 0, 0, 1,  0,  8'h00);
    add(0, 1, 8'hFF, 1, 1, 0, 2, 0, 0, 2,  0,  8'hFF);
    add(0, 1, 8'h00, 1, 1, 1, 1, 1, 0, 1,  0,  8'h00);
    // illegal step, resync, then a reversal through HOLD (no dir_change)
    add(1, 0, 8'h00, 0, 0, 0, 3, 0, 0, 0,  0,  8'h00);
    add(0, 1, 8'h10, 0, 0, 0, 0, 0, 0, 0,  0,  8'h10);
    add(0, 1, 8'h11, 1, 1, 1, 1, 0, 0, 1,  0,  8'h11);
    add(0, 1, 8'h20, 0, 1, 1, 0, 0, 1, 0,  1,  8'h20);
    add(0, 1, 8'h21, 1, 1, 1, 1, 0, 0, 1,  1,  8'h21);
    add(0, 1, 8'h21, 1, 0, 0, 0, 0, 0, 1,  1,  8'h21);
    add(0, 1, 8'h20, 1, 1, 0, 2, 0, 0, 1,  1,  8'h20);
    // gaps with valid low, then reset together with valid
    add(1, 0, 8'h00, 0, 0, 0, 3, 0, 0, 0,  0,  8'h00);
    add(0, 1, 8'h03, 0, 0, 0, 0, 0, 0, 0,  0,  8'h03);
    add(0, 0, 8'h04, 0, 0, 0, 0, 0, 0, 0,  0,  8'h03);
    add(0, 0, 8'h77, 0, 0, 0, 0, 0, 0, 0,  0,  8'h03);
    add(0, 0, 8'h04, 0, 0, 0, 0, 0, 0, 0,  0,  8'h03);
    add(0, 1, 8'h04, 1, 1, 1, 1, 0, 0, 1,  0,  8'h04);
    add(1, 1, 8'h09, 0, 0, 0, 3, 0, 0, 0,  0,  8'h00);
    add(0, 1, 8'h09, 0, 0, 0, 0, 0, 0, 0,  0,  8'h09);

    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].rst;
      valid = vecs[i].valid;
      q_drv = vecs[i].q;
      step_clk();
      check($sformatf("v%0d dec_valid", i),  32'(dec_valid),  32'(vecs[i].dv));
      check($sformatf("v%0d en_out", i),     32'(en_out),     32'(vecs[i].en));
      check($sformatf("v%0d dir_out", i),    32'(dir_out),    32'(vecs[i].dir));
      check($sformatf("v%0d state", i),      32'(state),      32'(vecs[i].st));
      check($sformatf("v%0d dir_change", i), 32'(dir_change), 32'(vecs[i].dc));
      check($sformatf("v%0d err", i),        32'(err),        32'(vecs[i].er));
      check($sformatf("v%0d run_len", i),    32'(run_len),    32'(vecs[i].rl));
      check($sformatf("v%0d err_cnt", i),    32'(err_cnt),    32'(vecs[i].ec));
      check($sformatf("v%0d prev_q", i),     32'(prev_q),     32'(vecs[i].pq));
    end

    // err_cnt saturation: 300 consecutive illegal steps (diff 0x37, then 0x10).
    rst = 1'b0; valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      q_drv = 8'(8'h40 + i * 16);
      step_clk();
      if (i == 0)   check("sat err_cnt first", 32'(err_cnt), 32'd1);
      if (i == 253) check("sat err_cnt 254",   32'(err_cnt), 32'd254);
    end
    check("sat err_cnt", 32'(err_cnt), 32'd255);
    check("sat err pulse", 32'(err), 32'd1);
    check("sat run_len", 32'(run_len), 32'd0);
    valid = 1'b0;
    step_clk();
    check("err pulse ends", 32'(err), 32'd0);
    check("err_cnt holds", 32'(err_cnt), 32'd255);

    // End-to-end against the counter model.
    rst = 1'b1; cnt_rst = 1'b1; use_cnt = 1'b1; valid = 1'b1;
    cnt_en = 1'b0; cnt_dir = 1'b0;
    step_clk();
    rst = 1'b0; cnt_rst = 1'b0;
    step_clk();  // sync sample
    exp_en = 1'b0; exp_dir = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i >= 400 && i < 700) begin
        cur_en = 1'b1; cur_dir = 1'b1;
      end else begin
        cur_en = 1'($urandom_range(0, 1));
        cur_dir = 1'($urandom_range(0, 1));
      end
      cnt_en = cur_en; cnt_dir = cur_dir;
      step_clk();
      check("e2e dec_valid", 32'(dec_valid), 32'd1);
      check("e2e en_out", 32'(en_out), 32'(exp_en));
      check("e2e dir_out", 32'(dir_out), 32'(exp_en & exp_dir));
      if (i == 699) check("e2e run_len saturate", 32'(run_len), 32'd255);
      exp_en = cur_en; exp_dir = cur_dir;
    end
    check("e2e err_cnt", 32'(err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
